// File: rtl/tug_pkg.sv
// tug_pkg: shared constants, output bundle and LFSR step for the tug-of-war press generator
package tug_pkg;
  localparam int LFSR_W = 10;
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;
  localparam logic [LFSR_W-1:0] LFSR_RESET = '0;
  localparam logic KEY_RELEASED = 1'b1;
  typedef struct packed {
    logic human;
    logic cpu;
    logic collision;
  } press_t;
  // XNOR feedback keeps all-zero legal; all-ones is the lockup state
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ~(v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO])};
  endfunction
endpackage

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and falling-edge detects the active-low key
module key_conditioner
  import tug_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic r_s1, r_s2, r_acc, r_acc_d;
  logic [CW-1:0] r_cnt;
  logic w_diff, w_done;
  assign w_diff  = r_s2 != r_acc;
  assign w_done  = w_diff && (r_cnt == CW'(DEBOUNCE - 1));
  assign o_press = r_acc_d && !r_acc;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= KEY_RELEASED;
      r_s2    <= KEY_RELEASED;
      r_acc   <= KEY_RELEASED;
      r_acc_d <= KEY_RELEASED;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_key_n;
      r_s2    <= r_s1;
      r_acc_d <= r_acc;
      if (w_done) r_acc <= r_s2;
      r_cnt   <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/tug_press_gen.sv
// tug_press_gen: one-cycle human/computer move pulses with collision cancel and game-over freeze
module tug_press_gen
  import tug_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int TICK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [8:0] difficulty,
  input  logic       game_over,
  output logic       human_press,
  output logic       cpu_press,
  output logic       collision
);
  localparam int TW = $clog2(TICK_DIV);
  logic [LFSR_W-1:0] r_lfsr;
  logic [TW-1:0] r_tick;
  press_t r_out;
  logic w_human, w_tick, w_cpu;
  key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_key (
    .clk    (clk),
    .reset  (reset),
    .i_key_n(key_n),
    .o_press(w_human)
  );
  assign w_tick = r_tick == TW'(TICK_DIV - 1);
  assign w_cpu  = w_tick && ({1'b0, difficulty} > r_lfsr);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_RESET;
      r_tick <= '0;
      r_out  <= '0;
    end else begin
      if (!game_over) begin
        r_tick <= w_tick ? '0 : r_tick + 1'b1;
        if (w_tick) r_lfsr <= lfsr_next(r_lfsr);
      end
      r_out.human     <= !game_over && w_human && !w_cpu;
      r_out.cpu       <= !game_over && w_cpu && !w_human;
      r_out.collision <= !game_over && w_cpu && w_human;
    end
  end
  assign human_press = r_out.human;
  assign cpu_press   = r_out.cpu;
  assign collision   = r_out.collision;
endmodule

// File: tb/tb_tug_press_gen.sv
// tb_tug_press_gen: directed and random stimulus checked against a behavioural model
module tb_tug_press_gen;
  localparam int D  = 4;
  localparam int TD = 8;
  logic clk = 0, reset = 0, key_n = 1, game_over = 0;
  logic [8:0] difficulty = 0;
  logic human_press, cpu_press, collision;
  int n_checks = 0, n_errors = 0;

  tug_press_gen #(.DEBOUNCE(D), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .difficulty(difficulty),
    .game_over(game_over), .human_press(human_press), .cpu_press(cpu_press),
    .collision(collision)
  );

  always #5 clk = ~clk;

  // Model: key accepted once the last D synchronized samples all differ from the accepted level
  logic [9:0] m_lfsr;
  int m_cnt;
  logic m_acc, m_pend, exp_h, exp_c, exp_x;
  logic [0:15] hist;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= 0; m_cnt <= 0; m_acc <= 1; m_pend <= 0; hist <= '1;
      exp_h <= 0; exp_c <= 0; exp_x <= 0;
    end else begin : mdl
      logic [0:15] h;
      logic rc, all_diff;
      h = {key_n, hist[0:14]};
      all_diff = 1'b1;
      for (int i = 2; i < 2 + D; i++) if (h[i] == m_acc) all_diff = 1'b0;
      rc = !game_over && (m_cnt % TD == TD - 1) && ({1'b0, difficulty} > m_lfsr);
      hist <= h;
      m_pend <= all_diff && m_acc;
      if (all_diff) m_acc <= ~m_acc;
      if (!game_over) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt % TD == TD - 1) m_lfsr <= {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
      end
      exp_h <= !game_over && m_pend && !rc;
      exp_c <= !game_over && rc && !m_pend;
      exp_x <= !game_over && rc && m_pend;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    int pulses = 0;
    difficulty = 9'd1; key_n = 1; game_over = 0;
    do_reset();
    n_checks++;
    if ({human_press, cpu_press, collision} !== 3'b000 || dut.r_lfsr !== 10'd0) begin
      n_errors++; $display("FAIL reset_state got=%b lfsr=%0d exp=000 lfsr=0", {human_press, cpu_press, collision}, dut.r_lfsr);
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({human_press, cpu_press, collision} !== {exp_h, exp_c, exp_x}) begin
        n_errors++; $display("FAIL reset_model c=%0d got=%b exp=%b", c, {human_press, cpu_press, collision}, {exp_h, exp_c, exp_x});
      end
      n_checks++;
      if (cpu_press !== (c == 8)) begin
        n_errors++; $display("FAIL reset_cpu_tick c=%0d got=%b exp=%b", c, cpu_press, c == 8);
      end
      pulses += cpu_press;
    end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("FAIL reset_cpu_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_human_hold();
    int pulses = 0;
    difficulty = 0; key_n = 1; game_over = 0;
    do_reset();
    key_n = 0;
    for (int c = 1; c <= 32; c++) begin
      if (c == 21) key_n = 1;
      @(negedge clk);
      n_checks++;
      if ({human_press, cpu_press, collision} !== {exp_h, exp_c, exp_x}) begin
        n_errors++; $display("FAIL hold_model c=%0d got=%b exp=%b", c, {human_press, cpu_press, collision}, {exp_h, exp_c, exp_x});
      end
      n_checks++;
      if (human_press !== (c == 3 + D)) begin
        n_errors++; $display("FAIL hold_human c=%0d got=%b exp=%b", c, human_press, c == 3 + D);
      end
      pulses += human_press;
    end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("FAIL hold_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_glitch();
    difficulty = 0; key_n = 1; game_over = 0;
    do_reset();
    key_n = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 4) key_n = 1;
      @(negedge clk);
      n_checks++;
      if (human_press !== 1'b0 || human_press !== exp_h) begin
        n_errors++; $display("FAIL glitch c=%0d got=%b exp=0 model=%b", c, human_press, exp_h);
      end
    end
  endtask

  task automatic test_collision();
    int hits = 0;
    difficulty = 9'd511; key_n = 1; game_over = 0;
    do_reset();
    @(negedge clk);
    key_n = 0;
    for (int c = 2; c <= 18; c++) begin
      @(negedge clk);
      n_checks++;
      if ({human_press, cpu_press, collision} !== {exp_h, exp_c, exp_x}) begin
        n_errors++; $display("FAIL coll_model c=%0d got=%b exp=%b", c, {human_press, cpu_press, collision}, {exp_h, exp_c, exp_x});
      end
      n_checks++;
      if ({human_press, cpu_press, collision} !== (c == 8 ? 3'b001 : c == 16 ? 3'b010 : 3'b000)) begin
        n_errors++; $display("FAIL coll_fixed c=%0d got=%b", c, {human_press, cpu_press, collision});
      end
      hits += collision;
    end
    n_checks++;
    if (hits != 1) begin n_errors++; $display("FAIL coll_count got=%0d exp=1", hits); end
  endtask

  task automatic test_game_over();
    difficulty = 9'd511; key_n = 0; game_over = 1;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      n_checks++;
      if ({human_press, cpu_press, collision} !== 3'b000 || dut.r_lfsr !== 10'd0) begin
        n_errors++; $display("FAIL gameover_freeze c=%0d got=%b lfsr=%0d exp=000 lfsr=0", c, {human_press, cpu_press, collision}, dut.r_lfsr);
      end
    end
    game_over = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      n_checks++;
      if ({human_press, cpu_press, collision} !== {1'b0, c == 8, 1'b0} || cpu_press !== exp_c) begin
        n_errors++; $display("FAIL gameover_resume c=%0d got=%b model_cpu=%b", c, {human_press, cpu_press, collision}, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid();
    difficulty = 9'd511; key_n = 0; game_over = 0;
    do_reset();
    repeat (7) @(negedge clk);
    n_checks++;
    if (human_press !== 1'b1) begin n_errors++; $display("FAIL mid_pre got=%b exp=1", human_press); end
    #2 reset = 1;
    #1;
    n_checks++;
    if ({human_press, cpu_press, collision} !== 3'b000 || dut.r_lfsr !== 10'd0) begin
      n_errors++; $display("FAIL mid_async got=%b lfsr=%0d exp=000 lfsr=0", {human_press, cpu_press, collision}, dut.r_lfsr);
    end
    @(negedge clk);
    reset = 0;
    for (int c = 1; c <= 25; c++) begin
      logic [9:0] want;
      @(negedge clk);
      want = c < 8 ? 10'd0 : c < 16 ? 10'd1 : c < 24 ? 10'd3 : 10'd7;
      n_checks++;
      if (dut.r_lfsr !== want) begin n_errors++; $display("FAIL mid_lfsr c=%0d got=%0d exp=%0d", c, dut.r_lfsr, want); end
      n_checks++;
      if ({human_press, cpu_press, collision} !== {exp_h, exp_c, exp_x} || human_press !== (c == 3 + D)) begin
        n_errors++; $display("FAIL mid_model c=%0d got=%b exp=%b", c, {human_press, cpu_press, collision}, {exp_h, exp_c, exp_x});
      end
    end
  endtask

  task automatic test_random();
    int run = 0;
    key_n = 1; game_over = 0; difficulty = 9'($urandom);
    do_reset();
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      n_checks++;
      if ({human_press, cpu_press, collision} !== {exp_h, exp_c, exp_x} || dut.r_lfsr !== m_lfsr) begin
        n_errors++; $display("FAIL random c=%0d got=%b exp=%b lfsr=%0d exp_lfsr=%0d", c, {human_press, cpu_press, collision}, {exp_h, exp_c, exp_x}, dut.r_lfsr, m_lfsr);
      end
      if (run == 0) begin key_n = ~key_n; run = $urandom_range(1, 10); end
      run--;
      if ($urandom_range(0, 15) == 0) difficulty = 9'($urandom);
      if ($urandom_range(0, 24) == 0) game_over = ~game_over;
    end
  endtask

  initial begin
    test_reset();
    test_human_hold();
    test_glitch();
    test_collision();
    test_game_over();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
